// File: rtl/apb_pwm_multi_pkg.sv
// Shared register map, CTRL bit positions and decode types for the multi-channel APB PWM.
package apb_pwm_pkg;

    localparam logic [11:0] ADDR_CTRL      = 12'h000;
    localparam logic [11:0] ADDR_PRESCALE  = 12'h004;
    localparam logic [11:0] ADDR_PERIOD    = 12'h008;
    localparam logic [11:0] ADDR_STATUS    = 12'h00C;
    localparam logic [11:0] ADDR_DUTY_BASE = 12'h010;
    localparam logic [11:0] DUTY_STRIDE    = 12'h004;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_CHEN = 16;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_PRESCALE,
        REG_PERIOD,
        REG_STATUS,
        REG_DUTY
    } reg_sel_e;

    function automatic logic [11:0] duty_addr(input int ch);
        return ADDR_DUTY_BASE + DUTY_STRIDE * 12'(ch);
    endfunction

endpackage

// File: rtl/apb_pwm_multi_if.sv
// APB3 bus bundle between the peripheral bus master and the PWM block.
interface apb_pwm_multi_if;

    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_pwm_multi_channel.sv
// One PWM channel: programmable duty, shadow copy taken at period boundaries, registered compare.
module pwm_channel
    import apb_pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             i_duty_we,
    input  logic [CNT_W-1:0] i_wdata,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] o_duty,
    output logic             o_pwm
);

    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] r_duty_sh;
    logic             r_pwm;

    // Compare against the shadow only, so mid-period writes cannot reshape the running pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_duty    <= '0;
            r_duty_sh <= '0;
            r_pwm     <= 1'b0;
        end else begin
            if (i_duty_we) r_duty <= i_wdata;
            if (i_load)    r_duty_sh <= r_duty;
            r_pwm <= i_en & (i_cnt < r_duty_sh);
        end
    end

    assign o_duty = r_duty;
    assign o_pwm  = r_pwm;

endmodule

// File: rtl/apb_pwm_multi.sv
// APB3 PWM block: shared prescaler/period counter driving NUM_CH channels, sticky wrap status.
// Optional wrap interrupt output enabled by defining APB_PWM_IRQ_EN.
module apb_pwm_multi
    import apb_pwm_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_pwm_multi_if.slave    apb,
    output logic [NUM_CH-1:0] pwm_out
`ifdef APB_PWM_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic [11:0]                  w_addr;
    reg_sel_e                     w_sel;
    logic [NUM_CH-1:0]            w_duty_hit;
    logic                         w_mapped;
    logic                         w_wr;
    logic [31:0]                  w_rdata;
    logic                         w_ie;
    logic                         w_tick;
    logic                         w_wrap_evt;
    logic                         w_run_start;
    logic                         w_load;
    logic [NUM_CH-1:0][CNT_W-1:0] w_duty;
    logic                         w_unused_ok;

    logic                  r_run;
    logic [NUM_CH-1:0]     r_ch_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [CNT_W-1:0]      r_period;
    logic [CNT_W-1:0]      r_period_sh;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wrap;

    assign w_addr = apb.PADDR[11:0];

    always_comb begin
        w_sel      = REG_NONE;
        w_duty_hit = '0;
        case (w_addr)
            ADDR_CTRL:     w_sel = REG_CTRL;
            ADDR_PRESCALE: w_sel = REG_PRESCALE;
            ADDR_PERIOD:   w_sel = REG_PERIOD;
            ADDR_STATUS:   w_sel = REG_STATUS;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_addr == duty_addr(i)) begin
                        w_duty_hit[i] = 1'b1;
                        w_sel         = REG_DUTY;
                    end
                end
            end
        endcase
    end

    assign w_mapped    = (w_sel != REG_NONE);
    assign w_wr        = apb.PSEL & apb.PENABLE & apb.PWRITE & w_mapped;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~w_mapped;

    // >= rather than == so shrinking PRESCALE/PERIOD below the live count still wraps promptly.
    assign w_tick      = r_run & (r_pcnt >= r_prescale);
    assign w_wrap_evt  = w_tick & (r_cnt >= r_period_sh);
    assign w_run_start = w_wr & (w_sel == REG_CTRL) & apb.PWDATA[CTRL_RUN] & ~r_run;
    assign w_load      = w_wrap_evt | w_run_start;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_run      <= 1'b0;
            r_ch_en    <= '0;
            r_prescale <= '0;
            r_period   <= '0;
        end else if (w_wr) begin
            case (w_sel)
                REG_CTRL: begin
                    r_run   <= apb.PWDATA[CTRL_RUN];
                    r_ch_en <= apb.PWDATA[CTRL_CHEN +: NUM_CH];
                end
                REG_PRESCALE: r_prescale <= apb.PWDATA[PRESCALE_W-1:0];
                REG_PERIOD:   r_period   <= apb.PWDATA[CNT_W-1:0];
                default: ;
            endcase
        end
    end

`ifdef APB_PWM_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr && w_sel == REG_CTRL) r_ie <= apb.PWDATA[CTRL_IE];
            r_irq <= r_wrap & r_ie;
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pcnt      <= '0;
            r_cnt       <= '0;
            r_period_sh <= '0;
        end else begin
            if (w_load) r_period_sh <= r_period;
            if (!r_run) begin
                r_pcnt <= '0;
                r_cnt  <= '0;
            end else if (w_tick) begin
                r_pcnt <= '0;
                r_cnt  <= w_wrap_evt ? '0 : r_cnt + CNT_W'(1);
            end else begin
                r_pcnt <= r_pcnt + PRESCALE_W'(1);
            end
        end
    end

    // A wrap landing in the same cycle as a write-1-clear keeps the flag set.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_wrap <= 1'b0;
        else          r_wrap <= w_wrap_evt |
                                (r_wrap & ~(w_wr & (w_sel == REG_STATUS) & apb.PWDATA[0]));
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .PCLK      (PCLK),
            .PRESETn   (PRESETn),
            .i_duty_we (w_wr & w_duty_hit[g]),
            .i_wdata   (apb.PWDATA[CNT_W-1:0]),
            .i_load    (w_load),
            .i_en      (r_run & r_ch_en[g]),
            .i_cnt     (r_cnt),
            .o_duty    (w_duty[g]),
            .o_pwm     (pwm_out[g])
        );
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_CTRL: begin
                w_rdata[CTRL_RUN]              = r_run;
                w_rdata[CTRL_IE]               = w_ie;
                w_rdata[CTRL_CHEN +: NUM_CH]   = r_ch_en;
            end
            REG_PRESCALE: w_rdata[PRESCALE_W-1:0] = r_prescale;
            REG_PERIOD:   w_rdata[CNT_W-1:0]      = r_period;
            REG_STATUS:   w_rdata[0]              = r_wrap;
            REG_DUTY: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_duty_hit[i]) w_rdata[CNT_W-1:0] = w_duty[i];
                end
            end
            default: ;
        endcase
    end

    assign apb.PRDATA = w_rdata;
    assign w_unused_ok = &{1'b0, apb.PADDR[31:12], apb.PWDATA};

endmodule

// File: tb/tb_apb_pwm_multi.sv
// Directed bench for apb_pwm_multi: reset, duty/shadow timing, edge duties, prescaler, status, decode.
module tb_apb_pwm_multi;

    localparam int NUM_CH = 4;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic [NUM_CH-1:0] pwm_out;
`ifdef APB_PWM_IRQ_EN
    logic              irq;
`endif

    apb_pwm_multi_if bus();

    apb_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(16), .PRESCALE_W(8)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus),
        .pwm_out (pwm_out)
`ifdef APB_PWM_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    logic wr_err;

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        #1 wr_err = bus.PSLVERR;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic e, output logic r);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        #1 begin d = bus.PRDATA; e = bus.PSLVERR; r = bus.PREADY; end
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge PCLK); #1;
        end
    endtask

    task automatic sample_pat(input int ch, input int n, output logic [63:0] pat);
        pat = '0;
        for (int k = 0; k < n; k++) begin
            pat[k] = pwm_out[ch];
            @(posedge PCLK); #1;
        end
    endtask

    task automatic sample_acc(input int n, output logic [NUM_CH-1:0] and_v, output logic [NUM_CH-1:0] or_v);
        and_v = '1;
        or_v  = '0;
        for (int k = 0; k < n; k++) begin
            and_v = and_v & pwm_out;
            or_v  = or_v | pwm_out;
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0]       rd;
    logic              e, r;
    logic [63:0]       pat;
    logic [NUM_CH-1:0] av, ov;
    logic [31:0]       ctrl_exp;
    int                t0;
    bit                seen;

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
`ifdef APB_PWM_IRQ_EN
        ctrl_exp = 32'h0001_0003;
`else
        ctrl_exp = 32'h0001_0001;
`endif

        // reset state
        repeat (3) @(posedge PCLK);
        #1 chk("rst_pwm", 32'(pwm_out), 32'h0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        for (int i = 0; i < 8; i++) begin
            apb_rd(32'(i * 4), rd, e, r);
            chk($sformatf("rst_rd_%0h", i * 4), rd, 32'h0);
            chk($sformatf("rst_err_%0h", i * 4), 32'(e), 32'h0);
        end
        chk("pready", 32'(r), 32'h1);

        // PERIOD=9, DUTY0=3: 3 high / 7 low
        apb_wr(32'h008, 32'd9);
        apb_wr(32'h010, 32'd3);
        apb_wr(32'h000, 32'h0001_0003);
        t0 = cyc;
        wait_cyc(t0 + 1);
        sample_pat(0, 17, pat);
        chk("pat_duty3", pat[31:0], 32'h0001_C07);

        // DUTY0=7 lands one cycle into a period: that period stays 3, the next is 7
        wait_cyc(t0 + 18);
        apb_wr(32'h010, 32'd7);
        wait_cyc(t0 + 22);
        sample_pat(0, 20, pat);
        chk("pat_midwr", pat[31:0], 32'h0008_FE03);

        apb_rd(32'h000, rd, e, r);
        chk("ctrl_rd", rd, ctrl_exp);
        apb_rd(32'h010, rd, e, r);
        chk("duty0_rd", rd, 32'd7);

        // duty 0 -> always low, duty above period -> always high
        apb_wr(32'h014, 32'd0);
        apb_wr(32'h018, 32'd12);
        apb_wr(32'h000, 32'h0007_0003);
        repeat (25) @(posedge PCLK);
        #1 sample_acc(15, av, ov);
        chk("out1_zero", 32'(ov[1]), 32'h0);
        chk("out2_one", 32'(av[2]), 32'h1);

        // PERIOD=0: counter parked at 0, out high iff duty != 0
        apb_wr(32'h008, 32'd0);
        apb_wr(32'h01C, 32'd1);
        apb_wr(32'h000, 32'h000F_0003);
        repeat (25) @(posedge PCLK);
        #1 sample_acc(10, av, ov);
        chk("per0_and", 32'(av), 32'hD);
        chk("per0_or", 32'(ov), 32'hD);

        // run=0 clears outputs one cycle later
        apb_wr(32'h000, 32'h0);
        @(posedge PCLK); #1;
        chk("run0_out", 32'(pwm_out), 32'h0);

        // PRESCALE=2, PERIOD=4, DUTY0=1: 3 high every 15 cycles
        apb_wr(32'h004, 32'd2);
        apb_wr(32'h008, 32'd4);
        apb_wr(32'h010, 32'd1);
        apb_wr(32'h000, 32'h0001_0003);
        t0 = cyc;
        wait_cyc(t0 + 1);
        sample_pat(0, 30, pat);
        chk("pat_psc", pat[31:0], 32'h0003_8007);

        // sticky wrap: wraps land at t0+15, +30, +45, +60
        apb_rd(32'h00C, rd, e, r);
        chk("sts_set", rd, 32'h1);
        apb_wr(32'h00C, 32'h1);
        apb_rd(32'h00C, rd, e, r);
        chk("sts_clr", rd, 32'h0);
        wait_cyc(t0 + 46);
        apb_wr(32'h00C, 32'h1);
        apb_rd(32'h00C, rd, e, r);
        chk("sts_clr2", rd, 32'h0);
        wait_cyc(t0 + 57);
        apb_wr(32'h00C, 32'h1);
        chk("w1c_land", 32'(cyc - t0), 32'd60);
        apb_rd(32'h00C, rd, e, r);
        chk("sts_setwins", rd, 32'h1);
`ifdef APB_PWM_IRQ_EN
        chk("irq_wrap", 32'(irq), 32'h1);
`endif

        // unmapped accesses
        apb_wr(32'h800, 32'hFFFF_FFFF);
        chk("slverr_wr", 32'(wr_err), 32'h1);
        apb_rd(32'h800, rd, e, r);
        chk("unmap_rd", rd, 32'h0);
        chk("unmap_err", 32'(e), 32'h1);
        apb_rd(32'h020, rd, e, r);
        chk("duty4_err", 32'(e), 32'h1);
        apb_rd(32'h008, rd, e, r);
        chk("period_kept", rd, 32'd4);
        apb_rd(32'h000, rd, e, r);
        chk("ctrl_kept", rd, ctrl_exp);

        // async reset while an output is high
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (pwm_out[0]) seen = 1'b1;
            else begin
                @(posedge PCLK); #1;
            end
        end
        chk("seen_high", 32'(seen), 32'h1);
        #2 PRESETn = 1'b0;
        #1 chk("arst_pwm", 32'(pwm_out), 32'h0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        apb_rd(32'h00C, rd, e, r);
        chk("arst_sts", rd, 32'h0);
        apb_rd(32'h000, rd, e, r);
        chk("arst_ctrl", rd, 32'h0);
        apb_rd(32'h008, rd, e, r);
        chk("arst_period", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
